reg_rd_stage: RTL and testbench

//  Parametrised register-read stage for the cpu15 pipeline. Owns the general register bank,

---
 rtl/cpu15_pkg.sv | 17 +
 rtl/reg_bank.sv | 46 ++++
 rtl/reg_rd_stage.sv | 81 ++++++++
 tb/tb_reg_rd_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// Shared cpu15 constants: default data width, register count and register indices.
package cpu15_pkg;

  localparam int CPU15_WIDTH = 16;
  localparam int CPU15_NREG  = 8;

  // Architectural register indices.
  localparam int CPU15_R0 = 0;
  localparam int CPU15_R1 = 1;
  localparam int CPU15_R2 = 2;
  localparam int CPU15_R3 = 3;
  localparam int CPU15_R4 = 4;
  localparam int CPU15_R5 = 5;
  localparam int CPU15_R6 = 6;
  localparam int CPU15_R7 = 7;

endpackage

// File: rtl/reg_bank.sv
// General register bank: NREG x WIDTH, one synchronous write port, two
// asynchronous read ports, synchronous clear. Out-of-range indices read 0
// and drop writes; with non-power-of-two NREG the index space is larger
// than the bank.
module reg_bank
  import cpu15_pkg::*;
#(
  parameter int WIDTH = CPU15_WIDTH,
  parameter int NREG  = CPU15_NREG,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [NREG-1:0][WIDTH-1:0] regs;

  // Storage: clear on reset, otherwise write the addressed entry only.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we && waddr == AW'(i)) regs[i] <= wdata;
      end
    end
  end

  // Read muxes: scanning only valid entries makes out-of-range reads 0.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (raddr_a == AW'(i)) rdata_a = regs[i];
      if (raddr_b == AW'(i)) rdata_b = regs[i];
    end
  end

endmodule

// File: rtl/reg_rd_stage.sv
// cpu15 register-read stage: owns the register bank, reads two operands
// with write-back bypass and holds them in a one-entry pipeline register
// with valid/stall/flush control. All outputs are flops.
module reg_rd_stage
  import cpu15_pkg::*;
#(
  parameter  int WIDTH = CPU15_WIDTH,
  parameter  int NREG  = CPU15_NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             CLK_DC,
  input  logic             RST_DC,
  input  logic             IN_VALID,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [AW-1:0]    N_REG_A_IN,
  input  logic [AW-1:0]    N_REG_B_IN,
  input  logic             WE,
  input  logic [AW-1:0]    N_REG_W,
  input  logic [WIDTH-1:0] REG_W_DATA,
  output logic             OUT_VALID,
  output logic [AW-1:0]    N_REG_A_OUT,
  output logic [AW-1:0]    N_REG_B_OUT,
  output logic [WIDTH-1:0] REG_A_OUT,
  output logic [WIDTH-1:0] REG_B_OUT
);

  logic [WIDTH-1:0] bank_a;
  logic [WIDTH-1:0] bank_b;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;

  reg_bank #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_bank (
    .clk     (CLK_DC),
    .rst     (RST_DC),
    .we      (WE),
    .waddr   (N_REG_W),
    .wdata   (REG_W_DATA),
    .raddr_a (N_REG_A_IN),
    .raddr_b (N_REG_B_IN),
    .rdata_a (bank_a),
    .rdata_b (bank_b)
  );

  // Operand select: a same-cycle write-back wins over the bank contents.
  always_comb begin
    opnd_a = bank_a;
    opnd_b = bank_b;
    if (WE && N_REG_W == N_REG_A_IN) opnd_a = REG_W_DATA;
    if (WE && N_REG_W == N_REG_B_IN) opnd_b = REG_W_DATA;
  end

  // Output register: reset > flush > stall (hold, refresh from write-back) > load.
  always_ff @(posedge CLK_DC) begin
    if (RST_DC) begin
      OUT_VALID   <= 1'b0;
      N_REG_A_OUT <= '0;
      N_REG_B_OUT <= '0;
      REG_A_OUT   <= '0;
      REG_B_OUT   <= '0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (STALL) begin
      // A held operand tracks write-back so it is current when the stall lifts.
      if (WE && N_REG_W == N_REG_A_OUT) REG_A_OUT <= REG_W_DATA;
      if (WE && N_REG_W == N_REG_B_OUT) REG_B_OUT <= REG_W_DATA;
    end else begin
      // Loaded even when IN_VALID is low; OUT_VALID marks the data dead.
      OUT_VALID   <= IN_VALID;
      N_REG_A_OUT <= N_REG_A_IN;
      N_REG_B_OUT <= N_REG_B_IN;
      REG_A_OUT   <= opnd_a;
      REG_B_OUT   <= opnd_b;
    end
  end

endmodule

// File: tb/tb_reg_rd_stage.sv
// Bench for reg_rd_stage: a directed vector table on the default build, a
// random run of a default and a WIDTH=8/NREG=6 build against a behavioural
// model, and a short sequence on out-of-range indices of the small build.
module tb_reg_rd_stage;
  import cpu15_pkg::*;

  logic        clk;
  logic        rst, in_valid, stall, flush, we;
  logic [2:0]  a_in, b_in, w_idx;
  logic [15:0] w_data;

  logic        v0, v1;
  logic [2:0]  ai0, bi0, ai1, bi1;
  logic [15:0] a0, b0;
  logic [7:0]  a1, b1;

  int checks   = 0;
  int failures = 0;

  reg_rd_stage dut0 (
    .CLK_DC(clk), .RST_DC(rst), .IN_VALID(in_valid), .STALL(stall), .FLUSH(flush),
    .N_REG_A_IN(a_in), .N_REG_B_IN(b_in), .WE(we), .N_REG_W(w_idx), .REG_W_DATA(w_data),
    .OUT_VALID(v0), .N_REG_A_OUT(ai0), .N_REG_B_OUT(bi0), .REG_A_OUT(a0), .REG_B_OUT(b0)
  );

  reg_rd_stage #(.WIDTH(8), .NREG(6)) dut1 (
    .CLK_DC(clk), .RST_DC(rst), .IN_VALID(in_valid), .STALL(stall), .FLUSH(flush),
    .N_REG_A_IN(a_in), .N_REG_B_IN(b_in), .WE(we), .N_REG_W(w_idx), .REG_W_DATA(w_data[7:0]),
    .OUT_VALID(v1), .N_REG_A_OUT(ai1), .N_REG_B_OUT(bi1), .REG_A_OUT(a1), .REG_B_OUT(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0: 16b/8 regs, 1: 8b/6 regs)
  logic [15:0] mbank [2][8];
  logic        mval [2];
  logic [2:0]  mai [2], mbi [2];
  logic [15:0] ma [2], mb [2];
  int          mnreg [2] = '{8, 6};
  logic [15:0] mmask [2] = '{16'hFFFF, 16'h00FF};

  function automatic logic [15:0] msel(int k, logic [2:0] idx);
    if (we && w_idx == idx) return w_data & mmask[k];
    if (int'(idx) < mnreg[k]) return mbank[k][idx];
    return 16'h0;
  endfunction

  task automatic model_edge();
    logic [15:0] na, nb;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) mbank[k][r] = '0;
        mval[k] = 0; mai[k] = 0; mbi[k] = 0; ma[k] = 0; mb[k] = 0;
      end else begin
        na = msel(k, a_in);
        nb = msel(k, b_in);
        if (flush) mval[k] = 0;
        else if (stall) begin
          if (we && w_idx == mai[k]) ma[k] = w_data & mmask[k];
          if (we && w_idx == mbi[k]) mb[k] = w_data & mmask[k];
        end else begin
          mval[k] = in_valid; mai[k] = a_in; mbi[k] = b_in; ma[k] = na; mb[k] = nb;
        end
        if (we && int'(w_idx) < mnreg[k]) mbank[k][w_idx] = w_data & mmask[k];
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("m0_valid", 32'(v0),  32'(mval[0]));
    chk("m0_aidx",  32'(ai0), 32'(mai[0]));
    chk("m0_bidx",  32'(bi0), 32'(mbi[0]));
    chk("m0_a",     32'(a0),  32'(ma[0]));
    chk("m0_b",     32'(b0),  32'(mb[0]));
    chk("m1_valid", 32'(v1),  32'(mval[1]));
    chk("m1_aidx",  32'(ai1), 32'(mai[1]));
    chk("m1_bidx",  32'(bi1), 32'(mbi[1]));
    chk("m1_a",     32'(a1),  32'(ma[1]));
    chk("m1_b",     32'(b1),  32'(mb[1]));
  endtask

  task automatic drive(logic r, logic iv, logic st, logic fl, logic w,
                       logic [2:0] a, logic [2:0] b, logic [2:0] wi, logic [15:0] wd);
    rst = r; in_valid = iv; stall = st; flush = fl; we = w;
    a_in = a; b_in = b; w_idx = wi; w_data = wd;
  endtask

  // One clock: inputs are already driven; model steps at the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table (default build)
  typedef struct {
    logic        rst, iv, st, fl, we;
    logic [2:0]  a, b, w;
    logic [15:0] wd;
    logic        ev;
    logic [2:0]  ea, eb;
    logic [15:0] eda, edb;
    string       name;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(string n, logic r, logic iv, logic st, logic fl, logic w,
                              int a, int b, int wi, logic [15:0] wd,
                              logic ev, int ea, int eb, logic [15:0] eda, logic [15:0] edb);
    vec_t v;
    v.name = n; v.rst = r; v.iv = iv; v.st = st; v.fl = fl; v.we = w;
    v.a = 3'(a); v.b = 3'(b); v.w = 3'(wi); v.wd = wd;
    v.ev = ev; v.ea = 3'(ea); v.eb = 3'(eb); v.eda = eda; v.edb = edb;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) mbank[k][r] = '0;
      mval[k] = 0; mai[k] = 0; mbi[k] = 0; ma[k] = 0; mb[k] = 0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //              rst iv st fl we  a         b         w         wdata      ev ea        eb        eda        edb
    tbl.push_back(mk("reset1",   1,0,0,0,0, CPU15_R0, CPU15_R0, CPU15_R0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("reset2",   1,1,0,0,1, CPU15_R3, CPU15_R4, CPU15_R3, 16'h9999, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("rd_r0r1",  0,1,0,0,0, CPU15_R0, CPU15_R1, 0, 16'h0000, 1, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk("rd_r2r3",  0,1,0,0,0, CPU15_R2, CPU15_R3, 0, 16'h0000, 1, 2, 3, 16'h0000, 16'h0000));
    tbl.push_back(mk("rd_r4r5",  0,1,0,0,0, CPU15_R4, CPU15_R5, 0, 16'h0000, 1, 4, 5, 16'h0000, 16'h0000));
    tbl.push_back(mk("rd_r6r7",  0,1,0,0,0, CPU15_R6, CPU15_R7, 0, 16'h0000, 1, 6, 7, 16'h0000, 16'h0000));
    tbl.push_back(mk("wr_r3",    0,0,0,0,1, 0, 0, CPU15_R3, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("rd_r3r3",  0,1,0,0,0, CPU15_R3, CPU15_R3, 0, 16'h0000, 1, 3, 3, 16'h1234, 16'h1234));
    tbl.push_back(mk("wr_r2",    0,0,0,0,1, 0, 0, CPU15_R2, 16'h0002, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("bypass",   0,1,0,0,1, CPU15_R5, CPU15_R2, CPU15_R5, 16'hBEEF, 1, 5, 2, 16'hBEEF, 16'h0002));
    tbl.push_back(mk("wr_r1",    0,0,0,0,1, 0, 0, CPU15_R1, 16'h0011, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("ld_r1r3",  0,1,0,0,0, CPU15_R1, CPU15_R3, 0, 16'h0000, 1, 1, 3, 16'h0011, 16'h1234));
    tbl.push_back(mk("stall_rf", 0,0,1,0,1, CPU15_R7, CPU15_R7, CPU15_R1, 16'h0022, 1, 1, 3, 16'h0022, 16'h1234));
    tbl.push_back(mk("flush_st", 0,1,1,1,1, 0, 0, CPU15_R3, 16'h5555, 0, 1, 3, 16'h0022, 16'h1234));
    tbl.push_back(mk("ld_r3r1",  0,1,0,0,0, CPU15_R3, CPU15_R1, 0, 16'h0000, 1, 3, 1, 16'h5555, 16'h0022));
    tbl.push_back(mk("stall_hd", 0,0,1,0,1, 0, 0, CPU15_R5, 16'h7777, 1, 3, 1, 16'h5555, 16'h0022));
    tbl.push_back(mk("rst_mid",  1,1,1,1,1, 0, 0, CPU15_R3, 16'hAAAA, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("post_rst", 0,1,0,0,0, CPU15_R3, CPU15_R5, 0, 16'h0000, 1, 3, 5, 16'h0000, 16'h0000));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].st, tbl[i].fl, tbl[i].we,
            tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].wd);
      tick();
      chk({tbl[i].name, "_valid"}, 32'(v0),  32'(tbl[i].ev));
      chk({tbl[i].name, "_aidx"},  32'(ai0), 32'(tbl[i].ea));
      chk({tbl[i].name, "_bidx"},  32'(bi0), 32'(tbl[i].eb));
      chk({tbl[i].name, "_a"},     32'(a0),  32'(tbl[i].eda));
      chk({tbl[i].name, "_b"},     32'(b0),  32'(tbl[i].edb));
      chk_model();
    end

    // ---------------- random run against the model, both builds
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(49) == 0), 1'($urandom), ($urandom_range(2) == 0),
            ($urandom_range(7) == 0), 1'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      tick();
      chk_model();
    end

    // ---------------- small build: out-of-range index 7 and top register r5
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);             tick();
    drive(0, 0, 0, 0, 1, 0, 0, 7, 16'h00AB);      tick(); chk_model();
    drive(0, 1, 0, 0, 1, 7, 0, 5, 16'h00FF);      tick();
    chk("p_r7_dropped", 32'(a1), 32'h00);
    chk("p_valid",      32'(v1), 32'h1);
    chk_model();
    drive(0, 1, 0, 0, 0, 5, 7, 0, 0);             tick();
    chk("p_r5_read",    32'(a1), 32'hFF);
    chk("p_r7_read",    32'(b1), 32'h00);
    chk_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
